// File: rtl/hpi_responder.sv
// Host port responder: 16-bit host bus with a pointer-addressed RAM, two mailboxes and a status word.
// Optional build macro HPI_RESP_IRQ_EN enables the registered host interrupt (D2H_FULL | OVF).
module hpi_responder #(
  parameter int ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              Reset_N,
  input  logic [1:0]        HPI_ADDR,
  input  logic              HPI_CS_N,
  input  logic              HPI_RD_N,
  input  logic              HPI_WR_N,
  inout  wire  [15:0]       HPI_DATA,
  output logic              HPI_INT,
  output logic [15:0]       mbx_rx_data,
  output logic              mbx_rx_valid,
  input  logic              mbx_rx_ack,
  input  logic [15:0]       mbx_tx_data,
  input  logic              mbx_tx_valid,
  output logic              mbx_tx_ready
);

  localparam int          DATA_W   = 16;
  localparam logic [1:0]  SEL_DATA = 2'd0;
  localparam logic [1:0]  SEL_MBX  = 2'd1;
  localparam logic [1:0]  SEL_ADDR = 2'd2;
  localparam logic [1:0]  SEL_STS  = 2'd3;

  logic [DATA_W-1:0] r_ram [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_active;
  logic              r_ignore;
  logic              r_is_rd;
  logic [1:0]        r_sel;
  logic [DATA_W-1:0] r_h2d_data;
  logic [DATA_W-1:0] r_d2h_data;
  logic              r_h2d_full;
  logic              r_d2h_full;
  logic              r_ovf;

  logic w_rd, w_wr, w_cond, w_start, w_end, w_end_ok;
  logic w_wr_start, w_rd_start, w_h2d_wr;
  logic w_data_end, w_mbx_rd_end, w_sts_rd_end, w_tx_load, w_drive;
  logic w_unused;

  assign w_rd       = !HPI_CS_N && !HPI_RD_N &&  HPI_WR_N;
  assign w_wr       = !HPI_CS_N && !HPI_WR_N &&  HPI_RD_N;
  // An access still open from before reset is held off until the bus goes fully idle.
  assign w_cond     = r_ignore ? (w_rd || w_wr) : (r_is_rd ? w_rd : w_wr);
  assign w_start    = !r_active && (w_rd || w_wr);
  assign w_end      = r_active && !w_cond;
  assign w_end_ok   = w_end && !r_ignore;
  assign w_wr_start = w_start && w_wr;
  assign w_rd_start = w_start && w_rd;
  assign w_h2d_wr   = w_wr_start && (HPI_ADDR == SEL_MBX);

  assign w_data_end   = w_end_ok && (r_sel == SEL_DATA);
  assign w_mbx_rd_end = w_end_ok && r_is_rd && (r_sel == SEL_MBX);
  assign w_sts_rd_end = w_end_ok && r_is_rd && (r_sel == SEL_STS);
  assign w_tx_load    = mbx_tx_valid && (!r_d2h_full || w_mbx_rd_end);

  assign w_drive  = r_active && !r_ignore && r_is_rd && w_rd;
  assign HPI_DATA = w_drive ? r_rdata : {DATA_W{1'bz}};
  assign w_unused = ^HPI_DATA[DATA_W-1:ADDR_W];

  assign mbx_rx_data  = r_h2d_data;
  assign mbx_rx_valid = r_h2d_full;
  assign mbx_tx_ready = !r_d2h_full;

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_active   <= 1'b1;
      r_ignore   <= 1'b1;
      r_is_rd    <= 1'b0;
      r_sel      <= SEL_DATA;
      r_ptr      <= '0;
      r_h2d_data <= '0;
      r_h2d_full <= 1'b0;
      r_d2h_data <= '0;
      r_d2h_full <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_start) begin
        r_active <= 1'b1;
        r_ignore <= 1'b0;
        r_is_rd  <= w_rd;
        r_sel    <= HPI_ADDR;
      end else if (w_end) begin
        r_active <= 1'b0;
      end

      if (w_wr_start && (HPI_ADDR == SEL_ADDR))
        r_ptr <= HPI_DATA[ADDR_W-1:0];
      else if (w_data_end)
        r_ptr <= r_ptr + 1'b1;

      // A coincident device ack loses to a host write, so the new word stays pending.
      if (w_h2d_wr) begin
        r_h2d_data <= HPI_DATA;
        r_h2d_full <= 1'b1;
      end else if (mbx_rx_ack) begin
        r_h2d_full <= 1'b0;
      end

      if (w_h2d_wr && r_h2d_full && !mbx_rx_ack)
        r_ovf <= 1'b1;
      else if (w_sts_rd_end)
        r_ovf <= 1'b0;

      if (w_tx_load) begin
        r_d2h_data <= mbx_tx_data;
        r_d2h_full <= 1'b1;
      end else if (w_mbx_rd_end) begin
        r_d2h_full <= 1'b0;
      end
    end
  end

  // Stage boundary: RAM write and read-data capture on the start cycle of an access.
  always_ff @(posedge Clk) begin
    if (w_wr_start && (HPI_ADDR == SEL_DATA))
      r_ram[r_ptr] <= HPI_DATA;
    if (w_rd_start) begin
      case (HPI_ADDR)
        SEL_DATA: r_rdata <= r_ram[r_ptr];
        SEL_MBX:  r_rdata <= r_d2h_data;
        SEL_ADDR: r_rdata <= DATA_W'(r_ptr);
        default:  r_rdata <= {13'b0, r_ovf, r_d2h_full, r_h2d_full};
      endcase
    end
  end

`ifdef HPI_RESP_IRQ_EN
  logic r_int;

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N)
      r_int <= 1'b0;
    else
      r_int <= r_d2h_full | r_ovf;
  end

  assign HPI_INT = r_int;
`else
  assign HPI_INT = 1'b0;
`endif

endmodule

// File: tb/tb_hpi_responder.sv
// Directed bench for hpi_responder: RAM/pointer, mailboxes, status, strobe conflict and reset abort.
module tb_hpi_responder;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MBX  = 2'd1;
  localparam logic [1:0] A_ADDR = 2'd2;
  localparam logic [1:0] A_STS  = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  addr;
  logic        cs_n, rd_n, wr_n;
  tri1  [15:0] bus;
  logic        tb_oe;
  logic [15:0] tb_dat;
  logic        hpi_int;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ack;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] rd_val;
  logic [15:0] exp_int;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign bus = tb_oe ? tb_dat : 16'hzzzz;

  hpi_responder #(.ADDR_W(10)) dut (
    .Clk         (clk),
    .Reset_N     (rst_n),
    .HPI_ADDR    (addr),
    .HPI_CS_N    (cs_n),
    .HPI_RD_N    (rd_n),
    .HPI_WR_N    (wr_n),
    .HPI_DATA    (bus),
    .HPI_INT     (hpi_int),
    .mbx_rx_data (rx_data),
    .mbx_rx_valid(rx_valid),
    .mbx_rx_ack  (rx_ack),
    .mbx_tx_data (tx_data),
    .mbx_tx_valid(tx_valid),
    .mbx_tx_ready(tx_ready)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cs_n  = 1'b1;
    rd_n  = 1'b1;
    wr_n  = 1'b1;
    tb_oe = 1'b0;
  endtask

  task automatic host_wr(input logic [1:0] a, input logic [15:0] d);
    addr = a; cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1;
    tb_oe = 1'b1; tb_dat = d;
    tick();
    idle();
    tick();
  endtask

  task automatic host_rd(input logic [1:0] a, output logic [15:0] d);
    addr = a; cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1;
    tick();
    d = bus;
    tick();
    idle();
    tick();
  endtask

  task automatic dev_push(input logic [15:0] d);
    tx_data = d; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  initial begin
`ifdef HPI_RESP_IRQ_EN
    exp_int = 16'h0001;
`else
    exp_int = 16'h0000;
`endif
    rst_n = 1'b0; addr = A_DATA; rx_ack = 1'b0; tx_data = '0; tx_valid = 1'b0; tb_dat = '0;
    idle();
    tick(2);
    chk("rst_bus_z",    bus,             16'hFFFF);
    chk("rst_rx_valid", {15'b0, rx_valid}, 16'h0000);
    chk("rst_tx_ready", {15'b0, tx_ready}, 16'h0001);
    chk("rst_int",      {15'b0, hpi_int},  16'h0000);
    chk("rst_rx_data",  rx_data,         16'h0000);
    rst_n = 1'b1;
    tick(2);
    host_rd(A_STS, rd_val);  chk("rst_status", rd_val, 16'h0000);
    host_rd(A_ADDR, rd_val); chk("rst_ptr", rd_val, 16'h0000);

    // Sequential RAM access through the auto-incrementing pointer
    host_wr(A_ADDR, 16'h0010);
    host_wr(A_DATA, 16'hAAAA);
    host_wr(A_DATA, 16'h5555);
    host_wr(A_ADDR, 16'h0010);
    host_rd(A_DATA, rd_val); chk("ram_rd0", rd_val, 16'hAAAA);
    host_rd(A_DATA, rd_val); chk("ram_rd1", rd_val, 16'h5555);
    host_rd(A_ADDR, rd_val); chk("ptr_after", rd_val, 16'h0012);

    // Pointer wrap at the top of RAM
    host_wr(A_ADDR, 16'h03FF);
    host_wr(A_DATA, 16'h1234);
    host_rd(A_ADDR, rd_val); chk("ptr_wrap", rd_val, 16'h0000);
    host_wr(A_ADDR, 16'h03FF);
    host_rd(A_DATA, rd_val); chk("ram_top", rd_val, 16'h1234);

    // Host-to-device mailbox with overflow
    host_wr(A_MBX, 16'h00C1);
    chk("h2d_valid1", {15'b0, rx_valid}, 16'h0001);
    host_wr(A_MBX, 16'h00C2);
    chk("h2d_data", rx_data, 16'h00C2);
    host_rd(A_STS, rd_val); chk("sts_ovf", rd_val, 16'h0005);
    host_rd(A_STS, rd_val); chk("sts_ovf_clr", rd_val, 16'h0001);
    rx_ack = 1'b1; tick(); rx_ack = 1'b0;
    chk("h2d_acked", {15'b0, rx_valid}, 16'h0000);
    host_rd(A_STS, rd_val); chk("sts_after_ack", rd_val, 16'h0000);

    // Ack coinciding with a host mailbox write keeps the new word pending
    host_wr(A_MBX, 16'h0011);
    addr = A_MBX; cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1; tb_oe = 1'b1; tb_dat = 16'h0022;
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
    idle();
    tick();
    chk("ack_wr_valid", {15'b0, rx_valid}, 16'h0001);
    chk("ack_wr_data",  rx_data, 16'h0022);
    rx_ack = 1'b1; tick(); rx_ack = 1'b0;
    host_rd(A_STS, rd_val);

    // Device-to-host mailbox, drop while full, load in read-end cycle
    dev_push(16'hBEEF);
    chk("d2h_ready0", {15'b0, tx_ready}, 16'h0000);
    tick();
    chk("d2h_int", {15'b0, hpi_int}, exp_int);
    dev_push(16'h1111);
    host_rd(A_STS, rd_val); chk("sts_d2h", rd_val, 16'h0002);
    addr = A_MBX; cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1;
    tick();
    chk("mbx_rd_beef", bus, 16'hBEEF);
    tick();
    idle();
    tx_data = 16'hCAFE; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("d2h_reload_full", {15'b0, tx_ready}, 16'h0000);
    host_rd(A_STS, rd_val); chk("sts_reload", rd_val, 16'h0002);
    host_rd(A_MBX, rd_val); chk("mbx_rd_cafe", rd_val, 16'hCAFE);
    host_rd(A_STS, rd_val); chk("sts_d2h_clr", rd_val, 16'h0000);
    chk("d2h_ready1", {15'b0, tx_ready}, 16'h0001);
    chk("int_clr", {15'b0, hpi_int}, 16'h0000);

    // Both strobes low: ignored, bus released
    host_wr(A_ADDR, 16'h0020);
    host_wr(A_DATA, 16'h7777);
    host_wr(A_ADDR, 16'h0020);
    addr = A_DATA; cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0; tb_oe = 1'b1; tb_dat = 16'h9999;
    tick(2);
    tb_oe = 1'b0;
    tick();
    chk("both_low_z", bus, 16'hFFFF);
    idle();
    tick();
    host_rd(A_ADDR, rd_val); chk("both_low_ptr", rd_val, 16'h0020);
    host_rd(A_DATA, rd_val); chk("both_low_ram", rd_val, 16'h7777);

    // Reset in the middle of a DATA read
    host_wr(A_ADDR, 16'h0030);
    host_wr(A_DATA, 16'h4321);
    host_wr(A_ADDR, 16'h0030);
    addr = A_DATA; cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1;
    tick();
    chk("pre_rst_drive", bus, 16'h4321);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_z", bus, 16'hFFFF);
    tick();
    rst_n = 1'b1;
    tick(2);
    chk("post_rst_held_z", bus, 16'hFFFF);
    idle();
    tick();
    host_rd(A_ADDR, rd_val); chk("post_rst_ptr", rd_val, 16'h0000);
    host_wr(A_ADDR, 16'h0030);
    host_rd(A_DATA, rd_val); chk("ram_kept", rd_val, 16'h4321);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hpi_responder.md
HPI_RESPONDER -- requirements
Module: hpi_responder

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of internal RAM (depth 2^ADDR_W x 16).
REQ-002 Clk  input  1  single clock; all logic rising-edge.
REQ-003 Reset_N  input  1  asynchronous, active-low reset.
REQ-004 HPI_ADDR  input  2  register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS.
REQ-005 HPI_CS_N, HPI_RD_N, HPI_WR_N  input  1 each  active-low chip select, read and write strobes; synchronous to Clk.
REQ-006 HPI_DATA  inout  16  bidirectional host data bus.
REQ-007 HPI_INT  output  1  active-high host interrupt.
REQ-008 mbx_rx_data  output  16  host-to-device mailbox contents.
REQ-009 mbx_rx_valid  output  1  high while the host-to-device mailbox is full.
REQ-010 mbx_rx_ack  input  1  one-cycle device pulse; empties the host-to-device mailbox.
REQ-011 mbx_tx_data  input  16  device-to-host mailbox write data.
REQ-012 mbx_tx_valid  input  1  device-to-host write request.
REQ-013 mbx_tx_ready  output  1  high when the device-to-host mailbox is empty.

Function
REQ-014 A read access SHALL be a cycle with CS_N=0, RD_N=0, WR_N=1; a write access SHALL be a cycle with CS_N=0, WR_N=0, RD_N=1; a cycle with both strobes low SHALL be ignored.
REQ-015 Access start SHALL be the first cycle of an access; access end SHALL be the first cycle after it with the access condition false.
REQ-016 A write SHALL take effect at the end of its start cycle; later cycles of the same access SHALL be ignored.
REQ-017 Read data SHALL be registered at the end of the start cycle and driven from the following cycle while the access holds; read latency is 1 cycle; the host holds RD_N low for 2 or more cycles.
REQ-018 HPI_DATA SHALL be driven only during a read access; it SHALL be high-Z otherwise, including during reset.
REQ-019 DATA write SHALL store HPI_DATA to RAM[ptr]; DATA read SHALL return RAM[ptr].
REQ-020 ptr SHALL increment by 1 at the access end of every DATA access.
REQ-021 ptr SHALL wrap from 2^ADDR_W-1 to 0.
REQ-022 ADDRESS write SHALL load ptr from HPI_DATA[ADDR_W-1:0]; ADDRESS read SHALL return ptr zero-extended.
REQ-023 MAILBOX write SHALL load the host-to-device register and set H2D_FULL.
REQ-024 If H2D_FULL is already set on a MAILBOX write, the register SHALL be overwritten and sticky OVF set.
REQ-025 MAILBOX read SHALL return the device-to-host register and clear D2H_FULL at access end.
REQ-026 STATUS read SHALL return {13'b0, OVF, D2H_FULL, H2D_FULL} and clear OVF at access end; STATUS write SHALL be ignored.
REQ-027 mbx_rx_ack SHALL clear H2D_FULL; if ack and a host MAILBOX write coincide, H2D_FULL SHALL stay 1 with the new data.
REQ-028 mbx_tx_valid while mbx_tx_ready=1 SHALL load the device-to-host register and set D2H_FULL.
REQ-029 mbx_tx_valid while mbx_tx_ready=0 SHALL be dropped, except in the MAILBOX-read end cycle, where the load wins and D2H_FULL stays 1.
REQ-030 mbx_rx_valid SHALL equal H2D_FULL; mbx_tx_ready SHALL equal ~D2H_FULL.

Reset
REQ-031 While Reset_N=0: ptr=0, H2D_FULL=0, D2H_FULL=0, OVF=0, mailbox registers=0, HPI_INT=0, mbx_rx_valid=0, mbx_tx_ready=1, HPI_DATA high-Z.
REQ-032 RAM contents SHALL NOT be reset.
REQ-033 Reset during an access SHALL abort it with no ptr increment; an access already in progress at deassertion SHALL be ignored until its end.

Configuration
REQ-034 Macro HPI_RESP_IRQ_EN defined: HPI_INT SHALL be registered D2H_FULL | OVF, asserting 1 cycle after either flag sets.
REQ-035 Macro HPI_RESP_IRQ_EN undefined: HPI_INT SHALL be constant 0; all other behaviour is unchanged.

Verification
REQ-036 Write ADDRESS=0x0010, then DATA writes 0xAAAA, 0x5555; write ADDRESS=0x0010 and read DATA twice -> 0xAAAA then 0x5555; ADDRESS read returns 0x0012.
REQ-037 ADDRESS=0x03FF (ADDR_W=10), DATA write 0x1234 -> ADDRESS read returns 0x0000; ADDRESS=0x03FF, DATA read returns 0x1234.
REQ-038 Host MAILBOX writes 0x00C1 then 0x00C2 with no ack -> mbx_rx_data=0x00C2, STATUS=0x0005; STATUS re-read=0x0001; mbx_rx_ack -> STATUS=0x0000.
REQ-039 Device mbx_tx_valid with 0xBEEF -> STATUS=0x0002, HPI_INT=1 (macro on) or 0 (macro off); MAILBOX read=0xBEEF, then STATUS=0x0000 and mbx_tx_ready=1.
REQ-040 RD_N and WR_N low together on DATA -> no RAM change, no ptr change, HPI_DATA high-Z.
REQ-041 Reset_N pulsed low mid DATA read -> bus high-Z immediately, ptr=0, no increment.
